ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus EX-stage operand network that feeds the 4-bit-controlled ALU.
- Latches decoded instruction fields from ID.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Selects operand sources and drives alu_op1, alu_op2 and alu_ctrl directly into the ALU.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
WIDTH, 32, datapath width
REG_AW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
rstn  in  1  synchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  WIDTH  instruction PC
id_rs1_data  in  WIDTH  register-file read data 1
id_rs2_data  in  WIDTH  register-file read data 2
id_imm  in  WIDTH  sign-extended immediate
id_rs1  in  REG_AW  source index 1
id_rs2  in  REG_AW  source index 2
id_rd  in  REG_AW  destination index
id_alu_ctrl  in  4  ALU operation code
id_op1_sel  in  1  0 = rs1, 1 = pc
id_op2_sel  in  1  0 = rs2, 1 = imm
id_reg_we  in  1  instruction writes rd
stall  in  1  hold the EX register
flush  in  1  replace the EX contents with a bubble
mem_fwd_we  in  1  MEM-stage instruction writes rd
mem_fwd_rd  in  REG_AW  MEM-stage destination index
mem_fwd_data  in  WIDTH  MEM-stage result
wb_fwd_we  in  1  WB-stage instruction writes rd
wb_fwd_rd  in  REG_AW  WB-stage destination index
wb_fwd_data  in  WIDTH  WB-stage result
ex_valid  out  1  EX holds a real instruction
ex_pc  out  WIDTH  latched PC
alu_op1  out  WIDTH  ALU operand 1
alu_op2  out  WIDTH  ALU operand 2
alu_ctrl  out  4  ALU operation code
ex_store_data  out  WIDTH  forwarded rs2 value, for stores
ex_rd  out  REG_AW  destination index
ex_reg_we  out  1  write enable, qualified by ex_valid

Behaviour:
- Single clock. Reset is synchronous and active-low, sampled on the rising edge of clk.
- Register update priority on each rising edge: !rstn > flush > stall > load.
- Reset: all latched fields go to 0, giving ex_valid=0, ex_reg_we=0, alu_ctrl=4'b0000, ex_rd=0, ex_pc=0.
  - Resulting outputs: alu_op1=alu_op2=0 and ex_store_data=0, provided no forward matches.
- flush=1: load a bubble.
  - valid=0, reg_we=0, alu_ctrl=4'b0000, rd=0, op selects=0.
  - All data fields = 0, and rs1 = rs2 = 0 so nothing forwards.
  - flush overrides a simultaneous stall.
- stall=1 (no flush): every latched field holds its value.
  - Forwarding is still re-evaluated every cycle against the current MEM/WB inputs, so a held instruction picks up results that arrive during the stall.
- Load: latch all id_* fields. Latency ID -> EX is 1 cycle.
  - If id_valid=0, the loaded entry is a bubble, identical to flush.
- Forwarding (combinational, applied separately to latched rs1 and rs2):
  - Use MEM data if mem_fwd_we=1, mem_fwd_rd!=0 and mem_fwd_rd==rs.
  - Otherwise use WB data if wb_fwd_we=1, wb_fwd_rd!=0 and wb_fwd_rd==rs.
  - Otherwise use the latched register-file data.
  - MEM has priority over WB. Index 0 is never forwarded; it reads as latched data, which is 0 from the register file.
- Operand select:
  - alu_op1 = op1_sel ? ex_pc : fwd_rs1.
  - alu_op2 = op2_sel ? imm : fwd_rs2.
- ex_store_data = fwd_rs2 always, regardless of op2_sel.
- Shift masking: when alu_ctrl is 4'b1000 (sll) or 4'b1001 (srl), alu_op2 is zero-extended from its low $clog2(WIDTH) bits. With WIDTH=32 that is bits [4:0]. All other codes pass alu_op2 unmasked.
- Output gating: ex_reg_we = latched reg_we & valid. alu_ctrl is passed through unchanged (4'b0000 = add for bubbles).
- No combinational path from stall, flush or any id_* input to any output.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with arbitrary id_* -> all outputs 0. Release with id_valid=1, id_rs1_data=5, id_imm=7, op2_sel=1, alu_ctrl=0000 -> next cycle alu_op1=5, alu_op2=7, ex_valid=1.
- Forward priority: latched rs1=3; mem_fwd(we=1, rd=3, data=0xAAAA) and wb_fwd(we=1, rd=3, data=0xBBBB) -> alu_op1=0xAAAA. Drop mem_fwd_we -> alu_op1=0xBBBB. Drop both -> latched rs1_data.
- x0: latched rs2=0, mem_fwd(we=1, rd=0, data=0x1234), op2_sel=0 -> alu_op2=0 and ex_store_data=0.
- Stall: load instr A (rs1=4), assert stall for 2 cycles while changing id_* -> A held, and wb_fwd(rd=4, data=9) appearing mid-stall gives alu_op1=9. Deassert stall -> next instruction loads.
- Flush+stall together with ex_valid=1, ex_reg_we=1 -> next cycle ex_valid=0, ex_reg_we=0, alu_ctrl=0000, ex_rd=0.
- Shift mask: alu_ctrl=1000, op2_sel=1, id_imm=0x0000_0025 -> alu_op2=0x5. Same imm with alu_ctrl=0000 -> alu_op2=0x25.

Source files
------------

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with MEM/WB forwarding and ALU operand select
module ex_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [WIDTH-1:0]  id_rs1_data,
    input  logic [WIDTH-1:0]  id_rs2_data,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_op1_sel,
    input  logic              id_op2_sel,
    input  logic              id_reg_we,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [WIDTH-1:0]  mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [WIDTH-1:0]  wb_fwd_data,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_pc,
    output logic [WIDTH-1:0]  alu_op1,
    output logic [WIDTH-1:0]  alu_op2,
    output logic [3:0]        alu_ctrl,
    output logic [WIDTH-1:0]  ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we
);

    localparam int SHW = $clog2(WIDTH);

    logic              valid_q,    valid_d;
    logic [WIDTH-1:0]  pc_q,       pc_d;
    logic [WIDTH-1:0]  rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]  rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0]  imm_q,      imm_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic              op1_sel_q,  op1_sel_d;
    logic              op2_sel_q,  op2_sel_d;
    logic              reg_we_q,   reg_we_d;

    // A flush or an invalid ID slot both load an all-zero bubble; stall holds.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        alu_ctrl_d = alu_ctrl_q;
        op1_sel_d  = op1_sel_q;
        op2_sel_d  = op2_sel_q;
        reg_we_d   = reg_we_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            alu_ctrl_d = 4'b0000;
            op1_sel_d  = 1'b0;
            op2_sel_d  = 1'b0;
            reg_we_d   = 1'b0;
        end else if (!stall) begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            alu_ctrl_d = id_alu_ctrl;
            op1_sel_d  = id_op1_sel;
            op2_sel_d  = id_op2_sel;
            reg_we_d   = id_reg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_ctrl_q <= 4'b0000;
            op1_sel_q  <= 1'b0;
            op2_sel_q  <= 1'b0;
            reg_we_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alu_ctrl_q <= alu_ctrl_d;
            op1_sel_q  <= op1_sel_d;
            op2_sel_q  <= op2_sel_d;
            reg_we_q   <= reg_we_d;
        end
    end

    // MEM is the younger producer, so it wins over WB; x0 never forwards.
    logic             mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic [WIDTH-1:0] fwd_rs1, fwd_rs2, op2_raw;
    logic             shift_op;

    always_comb begin
        mem_hit1 = mem_fwd_we && (mem_fwd_rd != '0) && (mem_fwd_rd == rs1_q);
        mem_hit2 = mem_fwd_we && (mem_fwd_rd != '0) && (mem_fwd_rd == rs2_q);
        wb_hit1  = wb_fwd_we  && (wb_fwd_rd  != '0) && (wb_fwd_rd  == rs1_q);
        wb_hit2  = wb_fwd_we  && (wb_fwd_rd  != '0) && (wb_fwd_rd  == rs2_q);
        fwd_rs1  = mem_hit1 ? mem_fwd_data : (wb_hit1 ? wb_fwd_data : rs1_data_q);
        fwd_rs2  = mem_hit2 ? mem_fwd_data : (wb_hit2 ? wb_fwd_data : rs2_data_q);
        op2_raw  = op2_sel_q ? imm_q : fwd_rs2;
        shift_op = (alu_ctrl_q == 4'b1000) || (alu_ctrl_q == 4'b1001);
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign alu_op1       = op1_sel_q ? pc_q : fwd_rs1;
    assign alu_op2       = shift_op ? {{(WIDTH-SHW){1'b0}}, op2_raw[SHW-1:0]} : op2_raw;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = reg_we_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_op1_sel, id_op2_sel, id_reg_we;
    logic        stall, flush;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_reg_we;
    logic [31:0] ex_pc, alu_op1, alu_op2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    ex_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel), .id_reg_we(id_reg_we),
        .stall(stall), .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctrl;
        logic        op1_sel, op2_sel, reg_we;
    } inst_t;

    inst_t m;
    logic  started = 1'b0;

    // Reference: what instruction sits in EX after each edge.
    always @(posedge clk) begin
        if (!rstn) begin
            m       <= '0;
            started <= 1'b1;
        end else if (flush || (!stall && !id_valid)) begin
            m <= '0;
        end else if (!stall) begin
            m <= '{valid: 1'b1, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                   imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, ctrl: id_alu_ctrl,
                   op1_sel: id_op1_sel, op2_sel: id_op2_sel, reg_we: id_reg_we};
        end
    end

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return rf;
        if (mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
        return rf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [31:0] e1, e2, es;
            es = operand(m.rs2, m.rs2_data);
            e1 = m.op1_sel ? m.pc : operand(m.rs1, m.rs1_data);
            e2 = m.op2_sel ? m.imm : es;
            if (m.ctrl == 4'd8 || m.ctrl == 4'd9) e2 = e2 % 32;
            chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("m_ex_pc", ex_pc, m.pc);
            chk("m_alu_op1", alu_op1, e1);
            chk("m_alu_op2", alu_op2, e2);
            chk("m_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m.ctrl});
            chk("m_store", ex_store_data, es);
            chk("m_ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            chk("m_reg_we", {31'd0, ex_reg_we}, {31'd0, m.reg_we && m.valid});
        end
    end

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [3:0] ctrl, input logic s1, input logic s2,
                          input logic we);
        id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_ctrl = ctrl;
        id_op1_sel = s1; id_op2_sel = s2; id_reg_we = we;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_we = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
        set_id(1'b1, 32'h40, 32'hDEAD, 32'hBEEF, 32'h99, 5'd3, 5'd4, 5'd9, 4'd5, 1'b1, 1'b1, 1'b1);

        // reset
        edge1();
        edge1();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op1", alu_op1, 32'd0);
        chk("rst_op2", alu_op2, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_reg_we", {31'd0, ex_reg_we}, 32'd0);

        rstn = 1'b1;
        set_id(1'b1, 32'h0, 32'd5, 32'd0, 32'd7, 5'd1, 5'd2, 5'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        edge1();
        chk("rel_op1", alu_op1, 32'd5);
        chk("rel_op2", alu_op2, 32'd7);
        chk("rel_valid", {31'd0, ex_valid}, 32'd1);

        // forwarding priority
        set_id(1'b1, 32'h10, 32'h1111, 32'h2222, 32'h0, 5'd3, 5'd6, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        edge1();
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAAAA;
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBBBB;
        #1 chk("fwd_mem", alu_op1, 32'hAAAA);
        mem_fwd_we = 1'b0;
        #1 chk("fwd_wb", alu_op1, 32'hBBBB);
        wb_fwd_we = 1'b0;
        #1 chk("fwd_none", alu_op1, 32'h1111);

        // x0 never forwards
        set_id(1'b1, 32'h20, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        edge1();
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h1234;
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h5678;
        #1 chk("x0_op2", alu_op2, 32'd0);
        chk("x0_store", ex_store_data, 32'd0);
        mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;

        // stall holds A and picks up a mid-stall WB result
        set_id(1'b1, 32'h100, 32'h44, 32'h0, 32'h0, 5'd4, 5'd0, 5'd7, 4'd2, 1'b0, 1'b0, 1'b1);
        edge1();
        stall = 1'b1;
        set_id(1'b1, 32'h200, 32'h55, 32'h66, 32'h3, 5'd5, 5'd6, 5'd8, 4'd3, 1'b0, 1'b0, 1'b1);
        edge1();
        chk("stall_pc", ex_pc, 32'h100);
        chk("stall_op1", alu_op1, 32'h44);
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'd9;
        #1 chk("stall_fwd", alu_op1, 32'd9);
        edge1();
        chk("stall2_pc", ex_pc, 32'h100);
        chk("stall2_rd", {27'd0, ex_rd}, 32'd7);
        chk("stall2_op1", alu_op1, 32'd9);
        stall = 1'b0; wb_fwd_we = 1'b0;
        edge1();
        chk("unstall_pc", ex_pc, 32'h200);
        chk("unstall_op1", alu_op1, 32'h55);
        chk("pre_flush_we", {31'd0, ex_reg_we}, 32'd1);

        // flush wins over stall
        flush = 1'b1; stall = 1'b1;
        edge1();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_we", {31'd0, ex_reg_we}, 32'd0);
        chk("flush_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("flush_rd", {27'd0, ex_rd}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // shift masking
        set_id(1'b1, 32'h30, 32'h1, 32'h0, 32'h25, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0, 1'b1, 1'b1);
        edge1();
        chk("sll_mask", alu_op2, 32'h5);
        set_id(1'b1, 32'h34, 32'h1, 32'h0, 32'h25, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1, 1'b1);
        edge1();
        chk("add_nomask", alu_op2, 32'h25);
        set_id(1'b1, 32'h38, 32'h1, 32'hFFFF_FFE3, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1001, 1'b1, 1'b0, 1'b1);
        edge1();
        chk("srl_mask", alu_op2, 32'h3);
        chk("srl_store", ex_store_data, 32'hFFFF_FFE3);
        chk("pc_op1", alu_op1, 32'h38);

        // id_valid=0 loads a bubble
        set_id(1'b0, 32'h3C, 32'h7, 32'h8, 32'h9, 5'd1, 5'd2, 5'd5, 4'd4, 1'b1, 1'b1, 1'b1);
        edge1();
        chk("bubble_rd", {27'd0, ex_rd}, 32'd0);
        chk("bubble_we", {31'd0, ex_reg_we}, 32'd0);
        chk("bubble_pc", ex_pc, 32'd0);

        // mixed traffic, checked by the reference each cycle
        for (int i = 0; i < 80; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                   4'($urandom_range(7, 10)), 1'($urandom), 1'($urandom), 1'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            mem_fwd_we = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
            wb_fwd_we = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
            edge1();
        end

        stall = 1'b0; flush = 1'b0;
        edge1();
        edge1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
